// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel position, registered sync/blank decode,
// line/frame strobes and a free-running frame counter for the scroll logic.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic [9:0]         hpos,
  output logic [9:0]         vpos,
  output logic               display_on,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 || FRAME_W < 1) begin : g_param_err
      $fatal(1, "vga_sync_gen: illegal timing parameters");
    end
  endgenerate

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [9:0] h_nxt, v_nxt;
  logic       new_line, new_frame;

  // Decode is done on the next counter values so every registered output
  // lines up with the position it describes.
  always_comb begin
    h_nxt = hpos + 10'd1;
    v_nxt = vpos;
    if (hpos == H_LAST) begin
      h_nxt = '0;
      v_nxt = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
    end
    new_line  = (h_nxt == 10'd0);
    new_frame = new_line && (v_nxt == 10'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos        <= H_LAST;
      vpos        <= V_LAST;
      display_on  <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else if (enable) begin
      hpos        <= h_nxt;
      vpos        <= v_nxt;
      display_on  <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      hsync       <= (h_nxt >= HS_FIRST && h_nxt <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_nxt >= VS_FIRST && v_nxt <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
      line_start  <= new_line;
      frame_start <= new_frame;
      if (new_frame) frame_count <= frame_count + FRAME_W'(1);
    end else begin
      // strobes never stretch across a stalled pixel
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 instance plus a tiny active-high instance
// with FRAME_W=2 for whole-frame and wrap behaviour.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst_a, en_a, rst_b, en_b;
  logic [9:0] hpos_a, vpos_a, hpos_b, vpos_b;
  logic       don_a, hs_a, vs_a, ls_a, fs_a;
  logic       don_b, hs_b, vs_b, ls_b, fs_b;
  logic [7:0] fc_a;
  logic [1:0] fc_b;

  vga_sync_gen dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a),
    .hpos(hpos_a), .vpos(vpos_a), .display_on(don_a),
    .hsync(hs_a), .vsync(vs_a), .line_start(ls_a),
    .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b1), .FRAME_W(2)
  ) dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b),
    .hpos(hpos_b), .vpos(vpos_b), .display_on(don_b),
    .hsync(hs_b), .vsync(vs_b), .line_start(ls_b),
    .frame_start(fs_b), .frame_count(fc_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int hs_cnt, hs_min, hs_max, don_fall;
  int vs_cnt, vs_min, vs_max, don_cnt, frames, last_fs;
  logic [1:0] fc_seq [0:7];

  initial begin
    rst_a = 1'b1; en_a = 1'b1; rst_b = 1'b1; en_b = 1'b0;
    tick(); tick();

    // reset state, default timing
    check("rst_hpos", hpos_a, 799);
    check("rst_vpos", vpos_a, 524);
    check("rst_hsync", hs_a, 1);
    check("rst_vsync", vs_a, 1);
    check("rst_don", don_a, 0);
    check("rst_fc", fc_a, 0);
    check("rst_ls", ls_a, 0);
    check("rst_fs", fs_a, 0);

    // first enabled edge after release lands on (0,0)
    rst_a = 1'b0;
    tick();
    check("first_hpos", hpos_a, 0);
    check("first_vpos", vpos_a, 0);
    check("first_don", don_a, 1);
    check("first_ls", ls_a, 1);
    check("first_fs", fs_a, 1);
    check("first_fc", fc_a, 1);
    tick();
    check("second_hpos", hpos_a, 1);
    check("second_ls", ls_a, 0);
    check("second_fs", fs_a, 0);

    // rest of line 0
    hs_cnt = 0; hs_min = 9999; hs_max = -1; don_fall = -1;
    for (int i = 0; i < 798; i++) begin
      tick();
      if (hs_a == 1'b0) begin
        hs_cnt++;
        if (int'(hpos_a) < hs_min) hs_min = int'(hpos_a);
        if (int'(hpos_a) > hs_max) hs_max = int'(hpos_a);
      end
      if (don_a == 1'b0 && don_fall < 0) don_fall = int'(hpos_a);
    end
    check("line_end_hpos", hpos_a, 799);
    check("line_end_vpos", vpos_a, 0);
    check("hsync_cycles", hs_cnt, 96);
    check("hsync_first", hs_min, 656);
    check("hsync_last", hs_max, 751);
    check("don_fall_hpos", don_fall, 640);

    // enable gating around the line wrap
    en_a = 1'b0; tick();
    check("gate0_hpos", hpos_a, 799);
    check("gate0_ls", ls_a, 0);
    en_a = 1'b1; tick();
    check("wrap_hpos", hpos_a, 0);
    check("wrap_vpos", vpos_a, 1);
    check("wrap_ls", ls_a, 1);
    check("wrap_fs", fs_a, 0);
    check("wrap_don", don_a, 1);
    en_a = 1'b0; tick();
    check("gate1_hpos", hpos_a, 0);
    check("gate1_ls", ls_a, 0);
    tick();
    check("gate2_hpos", hpos_a, 0);
    check("gate2_vpos", vpos_a, 1);
    en_a = 1'b1; tick();
    check("resume_hpos", hpos_a, 1);
    check("resume_ls", ls_a, 0);

    // asynchronous reset mid-line, checked between edges
    for (int i = 0; i < 299; i++) tick();
    check("pre_rst_hpos", hpos_a, 300);
    #2 rst_a = 1'b1;
    #1;
    check("async_hpos", hpos_a, 799);
    check("async_vpos", vpos_a, 524);
    check("async_hsync", hs_a, 1);
    check("async_fc", fc_a, 0);
    check("async_don", don_a, 0);
    rst_a = 1'b0;
    tick();
    check("rerun_hpos", hpos_a, 0);
    check("rerun_vpos", vpos_a, 0);
    check("rerun_fs", fs_a, 1);
    check("rerun_fc", fc_a, 1);

    // small active-high instance: reset state
    check("b_rst_hpos", hpos_b, 13);
    check("b_rst_vpos", vpos_b, 6);
    check("b_rst_hsync", hs_b, 0);
    check("b_rst_vsync", vs_b, 0);

    // five 14x7 frames, 98 clocks each
    rst_b = 1'b0; en_b = 1'b1;
    hs_cnt = 0; hs_min = 9999; hs_max = -1;
    vs_cnt = 0; vs_min = 9999; vs_max = -1;
    don_cnt = 0; frames = 0; last_fs = 0;
    for (int i = 1; i <= 490; i++) begin
      tick();
      if (hs_b) begin
        hs_cnt++;
        if (int'(hpos_b) < hs_min) hs_min = int'(hpos_b);
        if (int'(hpos_b) > hs_max) hs_max = int'(hpos_b);
      end
      if (vs_b) begin
        vs_cnt++;
        if (int'(vpos_b) < vs_min) vs_min = int'(vpos_b);
        if (int'(vpos_b) > vs_max) vs_max = int'(vpos_b);
      end
      if (don_b) don_cnt++;
      if (fs_b) begin
        if (frames > 0) check("b_frame_period", i - last_fs, 98);
        else check("b_first_fs_tick", i, 1);
        if (frames < 8) fc_seq[frames] = fc_b;
        frames++;
        last_fs = i;
      end
    end
    check("b_frames", frames, 5);
    check("b_fc0", fc_seq[0], 1);
    check("b_fc1", fc_seq[1], 2);
    check("b_fc2", fc_seq[2], 3);
    check("b_fc3", fc_seq[3], 0);
    check("b_fc4", fc_seq[4], 1);
    check("b_hsync_cycles", hs_cnt, 70);
    check("b_hsync_first", hs_min, 10);
    check("b_hsync_last", hs_max, 11);
    check("b_vsync_cycles", vs_cnt, 70);
    check("b_vsync_first", vs_min, 5);
    check("b_vsync_last", vs_max, 5);
    check("b_don_cycles", don_cnt, 160);
    check("b_end_hpos", hpos_b, 13);
    check("b_end_vpos", vpos_b, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
